// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory port between instruction fetch (0) and LSU (1).
// Optional wait-state watchdog enabled by defining ARB_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | port free; arbitrate eligible requests
// BUSY0 | access owned by requester 0, awaiting mem_ready
// BUSY1 | access owned by requester 1, awaiting mem_ready
module mem_port_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we0,
    input  logic             we1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             err,
    output logic             sel,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             err_q, err_d;

    logic elig0;
    logic elig1;
    logic grant_sel;
    logic timeout_hit;

    // A requester whose done is pulsing this cycle is still holding req; do not treat it as new.
    assign elig0     = req0 & ~done0_q;
    assign elig1     = req1 & ~done1_q;
    assign grant_sel = (elig0 & elig1) ? ~last_q : elig1;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wcnt_q, wcnt_d;

    assign timeout_hit = (state_q != IDLE) && (wcnt_q == CW'(TIMEOUT));

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == IDLE) begin
            wcnt_d = '0;
        end else if (!mem_ready && !timeout_hit) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    // Watchdog absent: BUSY waits for mem_ready indefinitely.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        err_d       = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                if (elig0 || elig1) begin
                    sel_d       = grant_sel;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_sel ? we1 : we0;
                    mem_addr_d  = grant_sel ? addr1 : addr0;
                    mem_wdata_d = grant_sel ? wdata1 : wdata0;
                    state_d     = grant_sel ? BUSY1 : BUSY0;
                end
            end

            BUSY0: begin
                if (mem_ready || timeout_hit) begin
                    state_d  = IDLE;
                    last_d   = 1'b0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done0_d  = 1'b1;
                    err_d    = ~mem_ready;
                    if (mem_ready) begin
                        rdata0_d = mem_rdata;
                    end
                end
            end

            BUSY1: begin
                if (mem_ready || timeout_hit) begin
                    state_d  = IDLE;
                    last_d   = 1'b1;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done1_d  = 1'b1;
                    err_d    = ~mem_ready;
                    if (mem_ready) begin
                        rdata1_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Reset mid-transaction simply abandons the access: no done, strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            sel_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            err_q       <= err_d;
        end
    end

    assign sel       = sel_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the watchdog step follows ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        we0, we1;
    logic        done0, done1;
    logic [15:0] rdata0, rdata1;
    logic        err, sel, mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.WIDTH(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err(err), .sel(sel),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        we0 = 1'b0; we1 = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_sel", {15'd0, sel}, 16'd0);
        chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rst_done0", {15'd0, done0}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_rdata0", rdata0, 16'h0000);

        // single read, ready immediately
        step();
        req0 = 1'b1; addr0 = 16'h0040; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
        step();
        chk("rd_sel", {15'd0, sel}, 16'd0);
        chk("rd_mem_en", {15'd0, mem_en}, 16'd1);
        chk("rd_mem_addr", mem_addr, 16'h0040);
        chk("rd_mem_we", {15'd0, mem_we}, 16'd0);
        chk("rd_done0_early", {15'd0, done0}, 16'd0);
        step();
        chk("rd_done0", {15'd0, done0}, 16'd1);
        chk("rd_rdata0", rdata0, 16'hBEEF);
        chk("rd_mem_en_drop", {15'd0, mem_en}, 16'd0);
        req0 = 1'b0; mem_ready = 1'b0;
        step();
        chk("rd_done0_pulse", {15'd0, done0}, 16'd0);

        // reset again so the tie below is the first after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_rdata0", rdata0, 16'h0000);

        // simultaneous requests: grants alternate 0,1,0,1
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'h0010; addr1 = 16'h0020; mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 16'hA000 + 16'(k);
            step();
            chk("rr_mem_en", {15'd0, mem_en}, 16'd1);
            chk("rr_sel", {15'd0, sel}, {15'd0, k[0]});
            chk("rr_addr", mem_addr, k[0] ? 16'h0020 : 16'h0010);
            step();
            chk("rr_done0", {15'd0, done0}, {15'd0, ~k[0]});
            chk("rr_done1", {15'd0, done1}, {15'd0, k[0]});
            if (k[0]) chk("rr_rdata1", rdata1, 16'hA000 + 16'(k));
            else      chk("rr_rdata0", rdata0, 16'hA000 + 16'(k));
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        step();
        chk("rr_idle", {15'd0, mem_en}, 16'd0);

        // write with 3 wait states; addr1 changes mid-transaction
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 16'h1234; mem_rdata = 16'h5555;
        step();
        chk("wr_sel", {15'd0, sel}, 16'd1);
        chk("wr_mem_we", {15'd0, mem_we}, 16'd1);
        chk("wr_mem_addr", mem_addr, 16'h0100);
        chk("wr_mem_wdata", mem_wdata, 16'h1234);
        addr1 = 16'hFFFF;
        for (int w = 0; w < 3; w++) begin
            step();
            chk("wr_hold_addr", mem_addr, 16'h0100);
            chk("wr_hold_en", {15'd0, mem_en}, 16'd1);
            chk("wr_no_done", {15'd0, done1}, 16'd0);
        end
        mem_ready = 1'b1;
        step();
        chk("wr_done1", {15'd0, done1}, 16'd1);
        chk("wr_rdata1", rdata1, 16'h5555);
        chk("wr_we_drop", {15'd0, mem_we}, 16'd0);
        req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;

        // req0 dropped during BUSY0, then held through done
        req0 = 1'b1; addr0 = 16'h0200; mem_rdata = 16'h7777;
        step();
        chk("drop_grant", {15'd0, mem_en}, 16'd1);
        chk("drop_sel", {15'd0, sel}, 16'd0);
        req0 = 1'b0;
        step();
        chk("drop_busy", {15'd0, mem_en}, 16'd1);
        mem_ready = 1'b1; req0 = 1'b1;
        step();
        chk("drop_done0", {15'd0, done0}, 16'd1);
        chk("drop_rdata0", rdata0, 16'h7777);
        mem_ready = 1'b0;
        step();
        chk("drop_no_regrant", {15'd0, mem_en}, 16'd0);
        req0 = 1'b0;
        step();
        chk("drop_idle", {15'd0, mem_en}, 16'd0);

        // reset while in BUSY1
        req1 = 1'b1; addr1 = 16'h0300;
        step();
        chk("rb_grant_sel", {15'd0, sel}, 16'd1);
        chk("rb_grant_en", {15'd0, mem_en}, 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rb_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rb_sel", {15'd0, sel}, 16'd0);
        chk("rb_addr", mem_addr, 16'h0000);
        chk("rb_done1", {15'd0, done1}, 16'd0);
        chk("rb_rdata1", rdata1, 16'h0000);
        req0 = 1'b1;
        step();
        chk("rb_tie_sel", {15'd0, sel}, 16'd0);
        chk("rb_tie_en", {15'd0, mem_en}, 16'd1);
        chk("rb_no_done1", {15'd0, done1}, 16'd0);
        mem_ready = 1'b1;
        step();
        chk("rb_done0", {15'd0, done0}, 16'd1);
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        step();
        chk("rb_idle", {15'd0, mem_en}, 16'd0);

        // memory never acknowledges
        req0 = 1'b1; addr0 = 16'h0400; mem_rdata = 16'hDEAD;
        step();
        chk("to_grant", {15'd0, mem_en}, 16'd1);
`ifdef ARB_TIMEOUT_EN
        for (int t = 0; t < 15; t++) begin
            step();
            chk("to_wait_err", {15'd0, err}, 16'd0);
            chk("to_wait_done", {15'd0, done0}, 16'd0);
        end
        step();
        chk("to_err", {15'd0, err}, 16'd1);
        chk("to_done0", {15'd0, done0}, 16'd1);
        chk("to_rdata0", rdata0, 16'h7777);
        chk("to_mem_en", {15'd0, mem_en}, 16'd0);
        req0 = 1'b0;
        step();
        chk("to_err_pulse", {15'd0, err}, 16'd0);
        chk("to_idle", {15'd0, mem_en}, 16'd0);
`else
        for (int t = 0; t < 20; t++) begin
            step();
            chk("wait_err", {15'd0, err}, 16'd0);
            chk("wait_done", {15'd0, done0}, 16'd0);
            chk("wait_en", {15'd0, mem_en}, 16'd1);
        end
        mem_ready = 1'b1;
        step();
        chk("wait_done0", {15'd0, done0}, 16'd1);
        chk("wait_rdata0", rdata0, 16'hDEAD);
        chk("wait_no_err", {15'd0, err}, 16'd0);
        req0 = 1'b0; mem_ready = 1'b0;
        step();
        chk("wait_idle", {15'd0, mem_en}, 16'd0);
`endif

        // mem_ready in IDLE is ignored
        mem_ready = 1'b1;
        step();
        step();
        chk("idle_ready_done0", {15'd0, done0}, 16'd0);
        chk("idle_ready_done1", {15'd0, done1}, 16'd0);
        chk("idle_ready_en", {15'd0, mem_en}, 16'd0);
        mem_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
